// File: rtl/xbar_core_demux.sv
// Core-side request demux: routes each core request to TCDM or the peripheral
// interconnect, with only one target in flight at a time. Optional stall counter: XBAR_DEMUX_PERF_EN.
`timescale 1ns/1ps
module xbar_core_demux #(
  parameter int unsigned           ADDR_WIDTH      = 32,
  parameter int unsigned           DATA_WIDTH      = 32,
  parameter int unsigned           BE_WIDTH        = DATA_WIDTH/8,
  parameter logic [ADDR_WIDTH-1:0] TCDM_BASE       = 32'h1000_0000,
  parameter logic [ADDR_WIDTH-1:0] TCDM_MASK       = 32'hFFC0_0000,
  parameter int unsigned           MAX_OUTSTANDING = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  data_barrier_i,
  input  logic                  data_exec_cancel_i,
  input  logic                  data_exec_stall_i,
  input  logic                  data_req_i,
  input  logic [ADDR_WIDTH-1:0] data_add_i,
  input  logic                  data_we_i,
  input  logic [DATA_WIDTH-1:0] data_wdata_i,
  input  logic [BE_WIDTH-1:0]   data_be_i,
  output logic                  data_gnt_o,
  output logic                  data_busy_o,
  input  logic                  data_r_gnt_i,
  output logic                  data_r_valid_o,
  output logic [DATA_WIDTH-1:0] data_r_rdata_o,
  output logic                  tcdm_req_o,
  output logic [ADDR_WIDTH-1:0] tcdm_add_o,
  output logic                  tcdm_we_o,
  output logic [DATA_WIDTH-1:0] tcdm_wdata_o,
  output logic [BE_WIDTH-1:0]   tcdm_be_o,
  input  logic                  tcdm_gnt_i,
  input  logic                  tcdm_r_valid_i,
  input  logic [DATA_WIDTH-1:0] tcdm_r_rdata_i,
  output logic                  periph_req_o,
  output logic [ADDR_WIDTH-1:0] periph_add_o,
  output logic                  periph_we_o,
  output logic [DATA_WIDTH-1:0] periph_wdata_o,
  output logic [BE_WIDTH-1:0]   periph_be_o,
  input  logic                  periph_gnt_i,
  input  logic                  periph_r_valid_i,
  input  logic [DATA_WIDTH-1:0] periph_r_rdata_i,
  output logic                  periph_r_ready_o
`ifdef XBAR_DEMUX_PERF_EN
  ,
  output logic [31:0]           perf_stall_o
`endif
);

  localparam int unsigned      CNT_W   = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_TCDM_PEND, S_PERIPH_PEND, S_DRAIN} state_e;
  typedef enum logic       {TGT_TCDM = 1'b0, TGT_PERIPH = 1'b1} tgt_e;

  state_e           state_q, state_d;
  tgt_e             last_tgt_q, last_tgt_d, tgt;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             allow, grant, periph_resp, resp_fire, resp_dec;

  assign tgt = ((data_add_i & TCDM_MASK) == TCDM_BASE) ? TGT_TCDM : TGT_PERIPH;

  // A new request may only join traffic already heading to the same target,
  // which keeps responses in order without a reorder buffer.
  assign allow = data_req_i & ~data_exec_cancel_i & ~data_exec_stall_i
               & (state_q != S_DRAIN) & (cnt_q < CNT_MAX)
               & ((cnt_q == '0) | (tgt == last_tgt_q));

  assign tcdm_req_o   = allow & (tgt == TGT_TCDM);
  assign periph_req_o = allow & (tgt == TGT_PERIPH);
  assign grant        = (tcdm_req_o & tcdm_gnt_i) | (periph_req_o & periph_gnt_i);
  assign data_gnt_o   = grant;

  assign tcdm_add_o     = data_add_i;
  assign tcdm_we_o      = data_we_i;
  assign tcdm_wdata_o   = data_wdata_i;
  assign tcdm_be_o      = data_be_i;
  assign periph_add_o   = data_add_i;
  assign periph_we_o    = data_we_i;
  assign periph_wdata_o = data_wdata_i;
  assign periph_be_o    = data_be_i;

  assign periph_r_ready_o = data_r_gnt_i;
  assign periph_resp      = periph_r_valid_i & data_r_gnt_i;
  assign data_r_valid_o   = tcdm_r_valid_i | periph_resp;
  assign data_r_rdata_o   = !data_r_valid_o ? '0 :
                            (last_tgt_q == TGT_TCDM) ? tcdm_r_rdata_i : periph_r_rdata_i;

  // Responses with nothing outstanding are protocol errors and leave cnt at 0.
  assign resp_fire   = (last_tgt_q == TGT_TCDM) ? tcdm_r_valid_i : periph_resp;
  assign resp_dec    = resp_fire & (cnt_q != '0);
  assign data_busy_o = (cnt_q != '0);

  always_comb begin
    cnt_d      = cnt_q;
    last_tgt_d = last_tgt_q;
    if (grant) last_tgt_d = tgt;
    case ({grant, resp_dec})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (grant) state_d = (tgt == TGT_TCDM) ? S_TCDM_PEND : S_PERIPH_PEND;
      end
      S_TCDM_PEND, S_PERIPH_PEND: begin
        if (data_barrier_i)     state_d = S_DRAIN;
        else if (cnt_d == '0)   state_d = S_IDLE;
      end
      S_DRAIN: begin
        if ((cnt_q == '0) && !data_barrier_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      last_tgt_q <= TGT_TCDM;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      last_tgt_q <= last_tgt_d;
      cnt_q      <= cnt_d;
    end
  end

`ifdef XBAR_DEMUX_PERF_EN
  logic [31:0] perf_q, perf_d;
  logic        stall_cyc;

  assign stall_cyc = data_req_i & ~data_gnt_o & ~data_exec_cancel_i;

  always_comb begin
    perf_d = perf_q;
    if (stall_cyc && (perf_q != 32'hFFFF_FFFF)) perf_d = perf_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) perf_q <= '0;
    else        perf_q <= perf_d;
  end

  assign perf_stall_o = perf_q;
`endif

endmodule

// File: tb/tb_xbar_core_demux.sv
// Self-checking bench for xbar_core_demux: directed scenarios plus randomized
// traffic against a transaction-count reference model.
`timescale 1ns/1ps
module tb_xbar_core_demux;
  localparam int MAXO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        data_barrier_i, data_exec_cancel_i, data_exec_stall_i, data_req_i;
  logic [31:0] data_add_i;
  logic        data_we_i;
  logic [31:0] data_wdata_i;
  logic [3:0]  data_be_i;
  logic        data_gnt_o, data_busy_o, data_r_gnt_i, data_r_valid_o;
  logic [31:0] data_r_rdata_o;
  logic        tcdm_req_o, tcdm_we_o, tcdm_gnt_i, tcdm_r_valid_i;
  logic [31:0] tcdm_add_o, tcdm_wdata_o, tcdm_r_rdata_i;
  logic [3:0]  tcdm_be_o;
  logic        periph_req_o, periph_we_o, periph_gnt_i, periph_r_valid_i, periph_r_ready_o;
  logic [31:0] periph_add_o, periph_wdata_o, periph_r_rdata_i;
  logic [3:0]  periph_be_o;
`ifdef XBAR_DEMUX_PERF_EN
  logic [31:0] perf_stall_o;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: number of requests in flight, which target they went to,
  // and whether a barrier is waiting for the core to go quiet.
  int m_cnt      = 0;
  bit m_last_tcdm = 1'b1;
  bit m_drain    = 1'b0;

  always #5 clk = ~clk;

  xbar_core_demux dut (
    .clk(clk), .rst_n(rst_n),
    .data_barrier_i(data_barrier_i), .data_exec_cancel_i(data_exec_cancel_i),
    .data_exec_stall_i(data_exec_stall_i), .data_req_i(data_req_i),
    .data_add_i(data_add_i), .data_we_i(data_we_i), .data_wdata_i(data_wdata_i),
    .data_be_i(data_be_i), .data_gnt_o(data_gnt_o), .data_busy_o(data_busy_o),
    .data_r_gnt_i(data_r_gnt_i), .data_r_valid_o(data_r_valid_o),
    .data_r_rdata_o(data_r_rdata_o),
    .tcdm_req_o(tcdm_req_o), .tcdm_add_o(tcdm_add_o), .tcdm_we_o(tcdm_we_o),
    .tcdm_wdata_o(tcdm_wdata_o), .tcdm_be_o(tcdm_be_o), .tcdm_gnt_i(tcdm_gnt_i),
    .tcdm_r_valid_i(tcdm_r_valid_i), .tcdm_r_rdata_i(tcdm_r_rdata_i),
    .periph_req_o(periph_req_o), .periph_add_o(periph_add_o), .periph_we_o(periph_we_o),
    .periph_wdata_o(periph_wdata_o), .periph_be_o(periph_be_o),
    .periph_gnt_i(periph_gnt_i), .periph_r_valid_i(periph_r_valid_i),
    .periph_r_rdata_i(periph_r_rdata_i), .periph_r_ready_o(periph_r_ready_o)
`ifdef XBAR_DEMUX_PERF_EN
    , .perf_stall_o(perf_stall_o)
`endif
  );

  wire [4:0] dvec = {tcdm_req_o, periph_req_o, data_gnt_o, data_busy_o, data_r_valid_o};

  function automatic bit m_hit(input logic [31:0] a);
    return (a & 32'hFFC0_0000) == 32'h1000_0000;
  endfunction

  function automatic bit e_allow();
    return data_req_i && !data_exec_cancel_i && !data_exec_stall_i && !m_drain &&
           (m_cnt < MAXO) && (m_cnt == 0 || m_hit(data_add_i) == m_last_tcdm);
  endfunction

  function automatic bit e_gnt();
    return e_allow() && (m_hit(data_add_i) ? tcdm_gnt_i : periph_gnt_i);
  endfunction

  function automatic bit e_rvalid();
    return tcdm_r_valid_i || (periph_r_valid_i && data_r_gnt_i);
  endfunction

  function automatic logic [4:0] e_vec();
    bit a = e_allow();
    bit h = m_hit(data_add_i);
    return {a && h, a && !h, e_gnt(), m_cnt != 0, e_rvalid()};
  endfunction

  task automatic tick();
    bit g, r, b, h;
    int old;
    @(posedge clk);
    g = e_gnt();
    h = m_hit(data_add_i);
    r = m_last_tcdm ? tcdm_r_valid_i : (periph_r_valid_i && data_r_gnt_i);
    b = data_barrier_i;
    old = m_cnt;
    if (g) begin m_cnt++; m_last_tcdm = h; end
    if (r && old > 0) m_cnt--;
    if (m_drain) m_drain = !(old == 0 && !b);
    else         m_drain = b && (old > 0);
    #1;
  endtask

  task automatic quiet();
    data_barrier_i = 0; data_exec_cancel_i = 0; data_exec_stall_i = 0; data_req_i = 0;
    data_add_i = 0; data_we_i = 0; data_wdata_i = 0; data_be_i = 0; data_r_gnt_i = 1;
    tcdm_gnt_i = 0; tcdm_r_valid_i = 0; tcdm_r_rdata_i = 0;
    periph_gnt_i = 0; periph_r_valid_i = 0; periph_r_rdata_i = 0;
  endtask

  task automatic test_reset();
    quiet();
    rst_n = 0;
    #12;
    checks++;
    if (dvec !== 5'b00000 || data_r_rdata_o !== 32'h0) begin
      errors++; $display("FAIL reset vec=%b rdata=%h exp 00000/0", dvec, data_r_rdata_o);
    end
    @(negedge clk); rst_n = 1;
    tick();
  endtask

  task automatic test_tcdm_read();
    data_req_i = 1; data_add_i = 32'h1000_0040; data_wdata_i = 32'hA5A5_0001;
    data_be_i = 4'hF; data_we_i = 0; tcdm_gnt_i = 1; #1;
    checks++;
    if (dvec !== 5'b10100) begin errors++; $display("FAIL tcdm_issue vec=%b exp 10100", dvec); end
    checks++;
    if (tcdm_add_o !== 32'h1000_0040 || periph_add_o !== 32'h1000_0040 ||
        periph_wdata_o !== 32'hA5A5_0001 || tcdm_be_o !== 4'hF) begin
      errors++; $display("FAIL forward tadd=%h padd=%h pwd=%h be=%h", tcdm_add_o, periph_add_o,
                         periph_wdata_o, tcdm_be_o);
    end
    tick();
    data_req_i = 0; tcdm_gnt_i = 0; tcdm_r_valid_i = 1; tcdm_r_rdata_i = 32'hDEAD_BEEF; #1;
    checks++;
    if (dvec !== 5'b00011 || data_r_rdata_o !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL tcdm_resp vec=%b rdata=%h exp 00011/deadbeef", dvec, data_r_rdata_o);
    end
    tick();
    tcdm_r_valid_i = 0; #1;
    checks++;
    if (data_busy_o !== 1'b0) begin errors++; $display("FAIL tcdm_idle busy=%b exp 0", data_busy_o); end
  endtask

  task automatic test_periph_block();
    data_req_i = 1; data_add_i = 32'h1A10_0000; periph_gnt_i = 1; #1;
    checks++;
    if (dvec !== 5'b01100) begin errors++; $display("FAIL periph_issue vec=%b exp 01100", dvec); end
    tick();
    data_add_i = 32'h1000_0100; tcdm_gnt_i = 1;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (dvec !== 5'b00010) begin errors++; $display("FAIL cross_hold vec=%b exp 00010", dvec); end
      tick();
    end
    periph_r_valid_i = 1; periph_r_rdata_i = 32'h1234_5678; #1;
    checks++;
    if (dvec !== 5'b00011 || data_r_rdata_o !== 32'h1234_5678) begin
      errors++; $display("FAIL periph_resp vec=%b rdata=%h exp 00011/12345678", dvec, data_r_rdata_o);
    end
    tick();
    periph_r_valid_i = 0; #1;
    checks++;
    if (dvec !== 5'b10100) begin errors++; $display("FAIL cross_release vec=%b exp 10100", dvec); end
    tick();
    data_req_i = 0; tcdm_gnt_i = 0; periph_gnt_i = 0; tcdm_r_valid_i = 1;
    tick();
    tcdm_r_valid_i = 0;
  endtask

  task automatic test_max_outstanding();
    data_req_i = 1; data_add_i = 32'h1000_0200; tcdm_gnt_i = 1;
    for (int i = 0; i < MAXO; i++) begin
      #1;
      checks++;
      if (data_gnt_o !== 1'b1) begin errors++; $display("FAIL fill_%0d gnt=%b exp 1", i, data_gnt_o); end
      tick();
    end
    #1;
    checks++;
    if (dvec !== 5'b00010) begin errors++; $display("FAIL full_stall vec=%b exp 00010", dvec); end
    tick();
    tcdm_r_valid_i = 1; #1;
    checks++;
    if (dvec !== 5'b00011) begin errors++; $display("FAIL full_resp vec=%b exp 00011", dvec); end
    tick();
    tcdm_r_valid_i = 0; #1;
    checks++;
    if (dvec !== 5'b10110) begin errors++; $display("FAIL refill vec=%b exp 10110", dvec); end
    tick();
    #1;
    checks++;
    if (dvec !== 5'b00010) begin errors++; $display("FAIL refull vec=%b exp 00010", dvec); end
    data_req_i = 0; tcdm_gnt_i = 0; tcdm_r_valid_i = 1;
    for (int i = 0; i < MAXO; i++) tick();
    tcdm_r_valid_i = 0; #1;
    checks++;
    if (data_busy_o !== 1'b0) begin errors++; $display("FAIL full_drain busy=%b exp 0", data_busy_o); end
  endtask

  task automatic test_r_gnt_backpressure();
    data_req_i = 1; data_add_i = 32'h1A10_0010; periph_gnt_i = 1;
    tick();
    data_req_i = 0; periph_gnt_i = 0;
    periph_r_valid_i = 1; periph_r_rdata_i = 32'hCAFE_0001; data_r_gnt_i = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (dvec !== 5'b00010 || periph_r_ready_o !== 1'b0) begin
        errors++; $display("FAIL bp_hold%0d vec=%b rdy=%b exp 00010/0", i, dvec, periph_r_ready_o);
      end
      tick();
    end
    data_r_gnt_i = 1; #1;
    checks++;
    if (dvec !== 5'b00011 || periph_r_ready_o !== 1'b1 || data_r_rdata_o !== 32'hCAFE_0001) begin
      errors++; $display("FAIL bp_accept vec=%b rdy=%b rdata=%h", dvec, periph_r_ready_o, data_r_rdata_o);
    end
    tick();
    periph_r_valid_i = 0; #1;
    checks++;
    if (data_busy_o !== 1'b0) begin errors++; $display("FAIL bp_idle busy=%b exp 0", data_busy_o); end
  endtask

  task automatic test_barrier();
    data_req_i = 1; data_add_i = 32'h1000_0300; tcdm_gnt_i = 1;
    tick(); tick();
    data_req_i = 0; data_barrier_i = 1;
    tick();
    data_req_i = 1; #1;
    checks++;
    if (dvec !== 5'b00010) begin errors++; $display("FAIL drain_block vec=%b exp 00010", dvec); end
    tcdm_r_valid_i = 1;
    tick();
    #1;
    checks++;
    if (dvec !== 5'b00011) begin errors++; $display("FAIL drain_last vec=%b exp 00011", dvec); end
    tick();
    tcdm_r_valid_i = 0; #1;
    checks++;
    if (dvec !== 5'b00000) begin errors++; $display("FAIL drain_hold vec=%b exp 00000", dvec); end
    tick();
    data_barrier_i = 0; #1;
    checks++;
    if (dvec !== 5'b00000) begin errors++; $display("FAIL drain_exit vec=%b exp 00000", dvec); end
    tick();
    #1;
    checks++;
    if (dvec !== 5'b10100) begin errors++; $display("FAIL post_barrier vec=%b exp 10100", dvec); end
    data_req_i = 0; tcdm_gnt_i = 0;
  endtask

  task automatic test_cancel_and_reset();
    data_req_i = 1; data_add_i = 32'h1000_0400; tcdm_gnt_i = 1; data_exec_cancel_i = 1; #1;
    checks++;
    if (dvec !== 5'b00000) begin errors++; $display("FAIL cancel vec=%b exp 00000", dvec); end
    tick();
    #1;
    checks++;
    if (data_busy_o !== 1'b0) begin errors++; $display("FAIL cancel_cnt busy=%b exp 0", data_busy_o); end
    data_exec_cancel_i = 0;
    tick(); tick(); tick();
    data_req_i = 0; #1;
    checks++;
    if (data_busy_o !== 1'b1) begin errors++; $display("FAIL pre_reset busy=%b exp 1", data_busy_o); end
    rst_n = 0; #1;
    m_cnt = 0; m_last_tcdm = 1'b1; m_drain = 1'b0;
    checks++;
    if (dvec !== 5'b00000) begin errors++; $display("FAIL async_reset vec=%b exp 00000", dvec); end
    @(negedge clk); rst_n = 1;
    tcdm_r_valid_i = 1;
    tick();
    tcdm_r_valid_i = 0; #1;
    checks++;
    if (data_busy_o !== 1'b0) begin errors++; $display("FAIL late_resp busy=%b exp 0", data_busy_o); end
    tcdm_gnt_i = 0;
  endtask

  task automatic test_random();
    logic [31:0] exp_rdata;
    for (int n = 0; n < 1500; n++) begin
      data_req_i         = ($urandom_range(9) < 7);
      data_exec_cancel_i = ($urandom_range(9) == 0);
      data_exec_stall_i  = ($urandom_range(9) == 0);
      data_barrier_i     = ($urandom_range(19) == 0);
      case ($urandom_range(5))
        0, 1:    data_add_i = 32'h1000_0000 | ($urandom & 32'h003F_FFFC);
        2:       data_add_i = ($urandom_range(1) == 1) ? 32'h1040_0000 : 32'h0FFF_FFFC;
        default: data_add_i = 32'h1A10_0000 | ($urandom & 32'h0000_FFFC);
      endcase
      data_we_i = $urandom_range(1); data_wdata_i = $urandom; data_be_i = 4'($urandom);
      tcdm_gnt_i = ($urandom_range(9) < 7); periph_gnt_i = ($urandom_range(9) < 7);
      data_r_gnt_i = ($urandom_range(9) < 7);
      tcdm_r_valid_i = 0; periph_r_valid_i = 0;
      tcdm_r_rdata_i = $urandom; periph_r_rdata_i = $urandom;
      if ((m_cnt > 0 && $urandom_range(9) < 4) || (m_cnt == 0 && $urandom_range(29) == 0)) begin
        if (m_last_tcdm) tcdm_r_valid_i = 1;
        else             periph_r_valid_i = 1;
      end
      #1;
      exp_rdata = !e_rvalid() ? 32'h0 : (tcdm_r_valid_i ? tcdm_r_rdata_i : periph_r_rdata_i);
      checks++;
      if (dvec !== e_vec() || data_r_rdata_o !== exp_rdata || periph_r_ready_o !== data_r_gnt_i ||
          tcdm_wdata_o !== data_wdata_i || periph_we_o !== data_we_i) begin
        errors++;
        $display("FAIL random_%0d vec=%b exp=%b rdata=%h exp=%h", n, dvec, e_vec(),
                 data_r_rdata_o, exp_rdata);
      end
      tick();
    end
    quiet();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_tcdm_read();
    test_periph_block();
    test_max_outstanding();
    test_r_gnt_backpressure();
    test_barrier();
    test_cancel_and_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/xbar_core_demux.md
Name: xbar_core_demux

Overview:
Core-side demultiplexer that consumes the core data bus (barrier/busy/exec_cancel/exec_stall/req/add/we/wdata/be/gnt, r_gnt/r_valid/r_rdata) and routes each request to either the TCDM interconnect or the peripheral interconnect by address region. It tracks outstanding transactions and keeps responses in order by allowing only one target to be outstanding at a time. It drives busy for barrier handling and drains in-flight traffic before a barrier completes.

Parameters:
ADDR_WIDTH, 32, address width
DATA_WIDTH, 32, data width
BE_WIDTH, DATA_WIDTH/8, byte-enable width
TCDM_BASE, 32'h1000_0000, TCDM region base
TCDM_MASK, 32'hFFC0_0000, region mask; TCDM hit = (add & TCDM_MASK) == TCDM_BASE
MAX_OUTSTANDING, 4, max in-flight requests; counter width $clog2(MAX_OUTSTANDING+1)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
data_barrier_i  in  1  barrier request from core
data_exec_cancel_i  in  1  cancel current (ungranted) request
data_exec_stall_i  in  1  core stall; no new request accepted
data_req_i  in  1  request valid
data_add_i  in  ADDR_WIDTH  address
data_we_i  in  1  write enable
data_wdata_i  in  DATA_WIDTH  write data
data_be_i  in  BE_WIDTH  byte enables
data_gnt_o  out  1  request granted
data_busy_o  out  1  outstanding != 0
data_r_gnt_i  in  1  core ready for response (peripheral back-pressure)
data_r_valid_o  out  1  response valid
data_r_rdata_o  out  DATA_WIDTH  response data
tcdm_req_o / tcdm_add_o / tcdm_we_o / tcdm_wdata_o / tcdm_be_o  out  1/ADDR/1/DATA/BE  TCDM request
tcdm_gnt_i  in  1  TCDM grant
tcdm_r_valid_i  in  1  TCDM response valid (not stallable)
tcdm_r_rdata_i  in  DATA_WIDTH  TCDM response data
periph_req_o / periph_add_o / periph_we_o / periph_wdata_o / periph_be_o  out  1/ADDR/1/DATA/BE  peripheral request
periph_gnt_i  in  1  peripheral grant
periph_r_valid_i  in  1  peripheral response valid
periph_r_rdata_i  in  DATA_WIDTH  peripheral response data
periph_r_ready_o  out  1  = data_r_gnt_i

Behaviour:
- Reset: cnt=0, state=IDLE, last_tgt=TCDM; all *_req_o, data_gnt_o, data_busy_o and data_r_valid_o are 0; data_r_rdata_o is 0.
- tgt = TCDM on region hit, else PERIPH. add/we/wdata/be are forwarded to both targets unconditionally.
- allow = data_req_i & ~data_exec_cancel_i & ~data_exec_stall_i & state!=DRAIN & cnt<MAX_OUTSTANDING & (cnt==0 | tgt==last_tgt).
- {tcdm,periph}_req_o = allow & tgt match. data_gnt_o = the selected target's gnt & allow. Request path is combinational (0-cycle).
- Grant: cnt+1 and last_tgt<=tgt. Response from last_tgt: cnt-1. Both in the same cycle: cnt unchanged.
- A response with cnt==0 is a protocol error: it is ignored and cnt saturates at 0.
- Response mux is combinational. data_r_valid_o = tcdm_r_valid_i | (periph_r_valid_i & data_r_gnt_i). rdata is selected by last_tgt. Both valid at once cannot occur by construction.
- FSM:
  - IDLE: cnt==0. Grant to TCDM -> TCDM_PEND; grant to PERIPH -> PERIPH_PEND; barrier_i -> stays IDLE (nothing to drain).
  - TCDM_PEND / PERIPH_PEND: cnt>0. Requests to the other target are held (gnt=0) until cnt reaches 0, then the FSM returns to IDLE. barrier_i -> DRAIN.
  - DRAIN: no grants. Exits to IDLE when cnt==0 and barrier_i is low; stays while barrier_i is high.
- data_busy_o = (cnt != 0), registered-free (combinational from cnt).
- exec_cancel: the request is not forwarded and not granted; in-flight responses still complete.
- Reset asserted mid-transaction clears cnt and state immediately; late responses after reset are dropped as errors.

Optional Feature:
XBAR_DEMUX_PERF_EN
- Defined: adds output perf_stall_o [31:0], a counter of cycles with data_req_i=1 and data_gnt_o=0 (excluding exec_cancel cycles). It resets to 0 and saturates at 32'hFFFF_FFFF.
- Undefined: the port and the counter are absent.

Test Plan:
- TCDM read at 0x1000_0040, tcdm_gnt_i=1 -> tcdm_req_o=1, gnt same cycle, busy=1. Next-cycle tcdm_r_valid_i with rdata 0xDEADBEEF -> data_r_valid_o=1, rdata 0xDEADBEEF, busy=0.
- Periph read at 0x1A10_0000 outstanding, then TCDM request -> data_gnt_o=0 until periph response; TCDM granted in the cycle after cnt=0.
- 4 back-to-back TCDM grants with responses withheld -> 5th request stalled (cnt=4). One response -> 5th granted, cnt stays 4.
- Periph response with data_r_gnt_i=0 for 3 cycles -> periph_r_ready_o=0 and data_r_valid_o=0; accepted on the cycle r_gnt=1.
- barrier_i=1 with 2 outstanding -> no grants, busy=1 until both responses arrive, then busy=0 and DRAIN->IDLE after barrier drops.
- exec_cancel_i=1 with req=1 -> no *_req_o, gnt=0, cnt unchanged. rst_n low with cnt=3 -> cnt=0, busy=0 asynchronously.
